tl_regslice: RTL

- Timing-isolation stage placed directly downstream of the core's TileLink host port (64-bit data, TL-C, all five channels), before the SoC interconnect.
- Each channel gets an independent skid buffer, so no combinational valid, ready or payload path exists between host side and device side.
- Protocol is unchanged; ordering within each channel is preserved.

---
 rtl/tl_regslice.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/tl_regslice.sv
// tl_regslice: per-channel skid buffers between the core's TL-C host port and the SoC interconnect.
// Build option TL_REGSLICE_FULL_EN: 2-entry full-rate slice; undefined gives the 1-entry half-rate slice.

module tl_regslice_slice #(
   parameter int DATA_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
);

`ifdef TL_REGSLICE_FULL_EN
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;
`else
   typedef enum logic {EMPTY = 1'b0, ONE = 1'b1} state_e;
`endif

   state_e            state_p1, state_nxt;
   logic [DATA_W-1:0] main_p1, main_nxt;
   logic              in_xfer, out_xfer;

   // Handshake outputs decode the state flops only; nothing combinational crosses the slice.
   assign out_valid = (state_p1 != EMPTY);
`ifdef TL_REGSLICE_FULL_EN
   assign in_ready  = (state_p1 != TWO);
`else
   assign in_ready  = (state_p1 == EMPTY);
`endif
   assign out_data  = main_p1;
   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = out_valid & out_ready;

`ifdef TL_REGSLICE_FULL_EN
   logic [DATA_W-1:0] skid_p1, skid_nxt;

   always_comb begin
      state_nxt = state_p1;
      main_nxt  = main_p1;
      skid_nxt  = skid_p1;
      case (state_p1)
         EMPTY: begin
            if (in_xfer) begin
               state_nxt = ONE;
               main_nxt  = in_data;
            end
         end
         ONE: begin
            if (in_xfer && !out_xfer) begin
               state_nxt = TWO;
               skid_nxt  = in_data;
            end else if (!in_xfer && out_xfer) begin
               state_nxt = EMPTY;
            end else if (in_xfer && out_xfer) begin
               main_nxt  = in_data;
            end
         end
         TWO: begin
            if (out_xfer) begin
               state_nxt = ONE;
               main_nxt  = skid_p1;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   // Stage p1: state, main and skid registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_p1 <= EMPTY;
         main_p1  <= '0;
         skid_p1  <= '0;
      end else begin
         state_p1 <= state_nxt;
         main_p1  <= main_nxt;
         skid_p1  <= skid_nxt;
      end
   end
`else
   always_comb begin
      state_nxt = state_p1;
      main_nxt  = main_p1;
      case (state_p1)
         EMPTY: begin
            if (in_xfer) begin
               state_nxt = ONE;
               main_nxt  = in_data;
            end
         end
         ONE: begin
            if (out_xfer) state_nxt = EMPTY;
         end
         default: state_nxt = EMPTY;
      endcase
   end

   // Stage p1: state and main register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_p1 <= EMPTY;
         main_p1  <= '0;
      end else begin
         state_p1 <= state_nxt;
         main_p1  <= main_nxt;
      end
   end
`endif

endmodule

module tl_regslice #(
   parameter int         AddrWidth   = 56,
   parameter int         SourceWidth = 4,
   parameter int         SinkWidth   = 1,
   parameter logic [4:0] ChannelMask = 5'b11111
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic                                host_a_valid_i,
   output logic                                host_a_ready_o,
   input  logic [82+SourceWidth+AddrWidth-1:0] host_a_i,
   output logic                                device_a_valid_o,
   input  logic                                device_a_ready_i,
   output logic [82+SourceWidth+AddrWidth-1:0] device_a_o,
   input  logic                                device_b_valid_i,
   output logic                                device_b_ready_o,
   input  logic [9+SourceWidth+AddrWidth-1:0]  device_b_i,
   output logic                                host_b_valid_o,
   input  logic                                host_b_ready_i,
   output logic [9+SourceWidth+AddrWidth-1:0]  host_b_o,
   input  logic                                host_c_valid_i,
   output logic                                host_c_ready_o,
   input  logic [74+SourceWidth+AddrWidth-1:0] host_c_i,
   output logic                                device_c_valid_o,
   input  logic                                device_c_ready_i,
   output logic [74+SourceWidth+AddrWidth-1:0] device_c_o,
   input  logic                                device_d_valid_i,
   output logic                                device_d_ready_o,
   input  logic [75+SourceWidth+SinkWidth-1:0] device_d_i,
   output logic                                host_d_valid_o,
   input  logic                                host_d_ready_i,
   output logic [75+SourceWidth+SinkWidth-1:0] host_d_o,
   input  logic                                host_e_valid_i,
   output logic                                host_e_ready_o,
   input  logic [SinkWidth-1:0]                host_e_i,
   output logic                                device_e_valid_o,
   input  logic                                device_e_ready_i,
   output logic [SinkWidth-1:0]                device_e_o
);

   localparam int WA = 82 + SourceWidth + AddrWidth;
   localparam int WB = 9 + SourceWidth + AddrWidth;
   localparam int WC = 74 + SourceWidth + AddrWidth;
   localparam int WD = 75 + SourceWidth + SinkWidth;
   localparam int WE = SinkWidth;

   // A and C flow host -> device; B and D flow device -> host; E flows host -> device.
   if (ChannelMask[0]) begin : g_a
      tl_regslice_slice #(.DATA_W(WA)) u_slice (
         .clk_i(clk_i), .rst_ni(rst_ni),
         .in_valid(host_a_valid_i), .in_ready(host_a_ready_o), .in_data(host_a_i),
         .out_valid(device_a_valid_o), .out_ready(device_a_ready_i), .out_data(device_a_o));
   end else begin : g_a_pass
      assign device_a_valid_o = host_a_valid_i;
      assign host_a_ready_o   = device_a_ready_i;
      assign device_a_o       = host_a_i;
   end

   if (ChannelMask[1]) begin : g_b
      tl_regslice_slice #(.DATA_W(WB)) u_slice (
         .clk_i(clk_i), .rst_ni(rst_ni),
         .in_valid(device_b_valid_i), .in_ready(device_b_ready_o), .in_data(device_b_i),
         .out_valid(host_b_valid_o), .out_ready(host_b_ready_i), .out_data(host_b_o));
   end else begin : g_b_pass
      assign host_b_valid_o   = device_b_valid_i;
      assign device_b_ready_o = host_b_ready_i;
      assign host_b_o         = device_b_i;
   end

   if (ChannelMask[2]) begin : g_c
      tl_regslice_slice #(.DATA_W(WC)) u_slice (
         .clk_i(clk_i), .rst_ni(rst_ni),
         .in_valid(host_c_valid_i), .in_ready(host_c_ready_o), .in_data(host_c_i),
         .out_valid(device_c_valid_o), .out_ready(device_c_ready_i), .out_data(device_c_o));
   end else begin : g_c_pass
      assign device_c_valid_o = host_c_valid_i;
      assign host_c_ready_o   = device_c_ready_i;
      assign device_c_o       = host_c_i;
   end

   if (ChannelMask[3]) begin : g_d
      tl_regslice_slice #(.DATA_W(WD)) u_slice (
         .clk_i(clk_i), .rst_ni(rst_ni),
         .in_valid(device_d_valid_i), .in_ready(device_d_ready_o), .in_data(device_d_i),
         .out_valid(host_d_valid_o), .out_ready(host_d_ready_i), .out_data(host_d_o));
   end else begin : g_d_pass
      assign host_d_valid_o   = device_d_valid_i;
      assign device_d_ready_o = host_d_ready_i;
      assign host_d_o         = device_d_i;
   end

   if (ChannelMask[4]) begin : g_e
      tl_regslice_slice #(.DATA_W(WE)) u_slice (
         .clk_i(clk_i), .rst_ni(rst_ni),
         .in_valid(host_e_valid_i), .in_ready(host_e_ready_o), .in_data(host_e_i),
         .out_valid(device_e_valid_o), .out_ready(device_e_ready_i), .out_data(device_e_o));
   end else begin : g_e_pass
      assign device_e_valid_o = host_e_valid_i;
      assign host_e_ready_o   = device_e_ready_i;
      assign device_e_o       = host_e_i;
   end

endmodule
